// File: rtl/interconnect_pkg.sv
// Shared types for the crypto data-bus interconnect: source IDs and arbiter states.
package interconnect_pkg;

  typedef logic [1:0] src_id_t;

  localparam src_id_t SRC_MEM  = 2'd0;
  localparam src_id_t SRC_SHA  = 2'd1;
  localparam src_id_t SRC_AES  = 2'd2;
  localparam src_id_t SRC_CTRL = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  function automatic logic [3:0] id_to_onehot(input src_id_t id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: first set request bit at or after the start pointer, wrapping.
module rr_pick4
  import interconnect_pkg::*;
(
  input  logic [3:0] req,
  input  src_id_t    start,
  output logic       valid,
  output src_id_t    winner
);

  // Walk from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    valid  = 1'b0;
    winner = start;
    for (int i = 3; i >= 0; i--) begin
      if (req[start + 2'(i)]) begin
        valid  = 1'b1;
        winner = start + 2'(i);
      end
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin owner arbiter for the shared crypto data bus, with a one-cycle turnaround.
// Optional grant watchdog is enabled by defining ARB_WATCHDOG_EN.
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | no owner; arbitrate pending requests
// OWNED | one grant asserted; wait for release
// TURN  | dead cycle after release; arbitrate again
module data_bus_arbiter
  import interconnect_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int MAX_HOLD = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [NUM_SRC-1:0] done_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output src_id_t            owner_id_o,
  output logic               bus_busy_o,
  output logic               grant_event_o,
  output logic               timeout_err_o
);

  if (NUM_SRC != 4) begin : g_bad_num_src
    $error("data_bus_arbiter supports exactly four sources");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_max_hold
    $error("data_bus_arbiter MAX_HOLD must be within 1..65535");
  end

  arb_state_t state;
  src_id_t    last_owner;
  logic       pick_valid;
  src_id_t    pick_id;
  logic       owner_done;
  logic       owner_req;
  logic       wd_expire;

  rr_pick4 u_pick (
    .req    (req_i[3:0]),
    .start  (last_owner + 2'd1),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  assign owner_done = done_i[owner_id_o];
  assign owner_req  = req_i[owner_id_o];

`ifdef ARB_WATCHDOG_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;

  assign wd_expire = (hold_cnt == HOLD_W'(MAX_HOLD));
`else
  assign wd_expire     = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_owner    <= SRC_CTRL;
      gnt_o         <= '0;
      owner_id_o    <= SRC_MEM;
      bus_busy_o    <= 1'b0;
      grant_event_o <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      timeout_err_o <= 1'b0;
      hold_cnt      <= '0;
`endif
    end else begin
      grant_event_o <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      timeout_err_o <= 1'b0;
`endif
      case (state)
        IDLE, TURN: begin
          if (pick_valid) begin
            state         <= OWNED;
            gnt_o         <= NUM_SRC'(id_to_onehot(pick_id));
            owner_id_o    <= pick_id;
            bus_busy_o    <= 1'b1;
            grant_event_o <= 1'b1;
`ifdef ARB_WATCHDOG_EN
            hold_cnt      <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        OWNED: begin
          if (owner_done || !owner_req || wd_expire) begin
            state      <= TURN;
            gnt_o      <= '0;
            bus_busy_o <= 1'b0;
            last_owner <= owner_id_o;
`ifdef ARB_WATCHDOG_EN
            // A genuine release in the expiry cycle is not an error.
            timeout_err_o <= wd_expire && owner_req && !owner_done;
`endif
          end else begin
`ifdef ARB_WATCHDOG_EN
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter; checks {gnt, owner, busy, event, timeout} each cycle.
// Watchdog scenario follows ARB_WATCHDOG_EN with MAX_HOLD = 4.
module tb_data_bus_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_i;
  logic [3:0] done_i;
  logic [3:0] gnt_o;
  logic [1:0] owner_id_o;
  logic       bus_busy_o;
  logic       grant_event_o;
  logic       timeout_err_o;
  logic [8:0] obs;

  int vectors = 0;
  int errors  = 0;

  data_bus_arbiter #(.NUM_SRC(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .done_i        (done_i),
    .gnt_o         (gnt_o),
    .owner_id_o    (owner_id_o),
    .bus_busy_o    (bus_busy_o),
    .grant_event_o (grant_event_o),
    .timeout_err_o (timeout_err_o)
  );

  assign obs = {gnt_o, owner_id_o, bus_busy_o, grant_event_o, timeout_err_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    req_i  = '0;
    done_i = '0;
    #12;
    vectors++;
    if (obs !== 9'b0000_00_0_0_0) begin
      errors++;
      $display("FAIL reset_values got %b want %b", obs, 9'b0000_00_0_0_0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (obs !== 9'b0000_00_0_0_0) begin
      errors++;
      $display("FAIL idle_after_reset got %b want %b", obs, 9'b0000_00_0_0_0);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] id;
    logic [3:0] oh;
    req_i = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      id = 2'(k % 4);
      oh = 4'b0001 << id;
      vectors++;
      if (obs !== {oh, id, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rr_grant k=%0d got %b want %b", k, obs, {oh, id, 1'b1, 1'b1, 1'b0});
      end
      tick();
      vectors++;
      if (obs !== {oh, id, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rr_hold k=%0d got %b want %b", k, obs, {oh, id, 1'b1, 1'b0, 1'b0});
      end
      done_i = oh;
      tick();
      vectors++;
      if (obs !== {4'b0000, id, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rr_turn k=%0d got %b want %b", k, obs, {4'b0000, id, 1'b0, 1'b0, 1'b0});
      end
      done_i = '0;
      if (k == 4) req_i = '0;
      tick();
    end
  endtask

  task automatic test_single_grant();
    req_i = 4'b0100;
    tick();
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (obs !== {4'b0100, 2'd2, 1'b1, (c == 0), 1'b0}) begin
        errors++;
        $display("FAIL single_hold c=%0d got %b want %b", c, obs, {4'b0100, 2'd2, 1'b1, (c == 0), 1'b0});
      end
      if (c == 3) done_i = 4'b0100;
      tick();
    end
    vectors++;
    if (obs !== {4'b0000, 2'd2, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_release got %b want %b", obs, {4'b0000, 2'd2, 1'b0, 1'b0, 1'b0});
    end
    req_i  = '0;
    done_i = '0;
    tick();
    vectors++;
    if (obs !== {4'b0000, 2'd2, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_idle_owner got %b want %b", obs, {4'b0000, 2'd2, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_non_owner_done();
    req_i = 4'b0010;
    tick();
    vectors++;
    if (obs !== {4'b0010, 2'd1, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sha_grant got %b want %b", obs, {4'b0010, 2'd1, 1'b1, 1'b1, 1'b0});
    end
    done_i = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (obs !== {4'b0010, 2'd1, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL foreign_done c=%0d got %b want %b", c, obs, {4'b0010, 2'd1, 1'b1, 1'b0, 1'b0});
      end
    end
    done_i = '0;
    req_i  = '0;
    tick();
    vectors++;
    if (obs !== {4'b0000, 2'd1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL req_drop_release got %b want %b", obs, {4'b0000, 2'd1, 1'b0, 1'b0, 1'b0});
    end
    done_i = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (obs !== {4'b0000, 2'd1, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_done c=%0d got %b want %b", c, obs, {4'b0000, 2'd1, 1'b0, 1'b0, 1'b0});
      end
    end
    done_i = '0;
  endtask

  task automatic test_reset_mid_grant();
    req_i = 4'b0001;
    tick();
    vectors++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mem_grant got %b want %b", obs, {4'b0001, 2'd0, 1'b1, 1'b1, 1'b0});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 9'b0000_00_0_0_0) begin
      errors++;
      $display("FAIL async_reset got %b want %b", obs, 9'b0000_00_0_0_0);
    end
    req_i = 4'b1001;
    #2;
    rst_n = 1'b1;
    tick();
    vectors++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pointer_after_reset got %b want %b", obs, {4'b0001, 2'd0, 1'b1, 1'b1, 1'b0});
    end
    req_i = 4'b1000;
    tick();
    vectors++;
    if (obs !== {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mem_release got %b want %b", obs, {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    end
    tick();
    vectors++;
    if (obs !== {4'b1000, 2'd3, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ctrl_grant got %b want %b", obs, {4'b1000, 2'd3, 1'b1, 1'b1, 1'b0});
    end
    req_i = '0;
    tick();
    tick();
  endtask

  task automatic test_hold_limit();
    req_i = 4'b0100;
    tick();
    vectors++;
    if (obs !== {4'b0100, 2'd2, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL aes_grant got %b want %b", obs, {4'b0100, 2'd2, 1'b1, 1'b1, 1'b0});
    end
    req_i = 4'b0101;
`ifdef ARB_WATCHDOG_EN
    for (int c = 1; c <= MAX_HOLD; c++) begin
      tick();
      vectors++;
      if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL wd_hold c=%0d got %b want %b", c, obs, {4'b0100, 2'd2, 1'b1, 1'b0, 1'b0});
      end
    end
    tick();
    vectors++;
    if (obs !== {4'b0000, 2'd2, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wd_revoke got %b want %b", obs, {4'b0000, 2'd2, 1'b0, 1'b0, 1'b1});
    end
`else
    for (int c = 1; c <= 1000; c++) begin
      tick();
      vectors++;
      if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL long_hold c=%0d got %b want %b", c, obs, {4'b0100, 2'd2, 1'b1, 1'b0, 1'b0});
      end
    end
    done_i = 4'b0100;
    tick();
    vectors++;
    if (obs !== {4'b0000, 2'd2, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL long_release got %b want %b", obs, {4'b0000, 2'd2, 1'b0, 1'b0, 1'b0});
    end
    done_i = '0;
`endif
    tick();
    vectors++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pending_mem got %b want %b", obs, {4'b0001, 2'd0, 1'b1, 1'b1, 1'b0});
    end
    req_i = 4'b0001;
  endtask

  task automatic test_back_to_back();
    done_i = 4'b0001;
    tick();
    vectors++;
    if (obs !== {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_turn got %b want %b", obs, {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    end
    done_i = '0;
    tick();
    vectors++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_regrant got %b want %b", obs, {4'b0001, 2'd0, 1'b1, 1'b1, 1'b0});
    end
    req_i = '0;
    tick();
    vectors++;
    if (obs !== {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_release got %b want %b", obs, {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_grant();
    test_non_owner_done();
    test_reset_mid_grant();
    test_hold_limit();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Round-robin arbiter that grants exclusive ownership of the shared crypto data bus to one of four requesters (mem, sha, aes, ctrl). It sits beside the ack bus. It takes per-source request and done strobes and drives one-hot grants, the owner ID and a grant-event pulse. A one-cycle turnaround separates consecutive owners. An optional watchdog revokes a grant held too long.

## Interface
- `NUM_SRC`, 4: number of requesters. Fixed at 4; the ID is 2 bits.
- `MAX_HOLD`, 255: watchdog limit in grant cycles. Used only with `ARB_WATCHDOG_EN`. Range 1..65535.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_i` in 4: request per source. Index = source ID: 0 mem, 1 sha, 2 aes, 3 ctrl. Level, held until granted.
- `done_i` in 4: release strobe per source. Only the current owner's bit is honoured.
- `gnt_o` out 4: one-hot grant. All zero when the bus is free.
- `owner_id_o` out 2: ID of the current or most recent owner.
- `bus_busy_o` out 1: high while any grant is asserted.
- `grant_event_o` out 1: one-cycle pulse in the first cycle of each new grant.
- `timeout_err_o` out 1: one-cycle pulse on a watchdog revoke. Tied 0 without the macro.

## Operation
- States:
  - IDLE: no owner; arbitrate.
  - OWNED: exactly one `gnt_o` bit high.
  - TURN: one dead cycle after a release.
- IDLE:
  - If any `req_i` bit is set, register the winner; go to OWNED next edge.
  - Otherwise stay in IDLE.
- Winner selection:
  - Search starts at `(last_owner + 1) mod 4` and increments modulo 4.
  - The first set bit wins.
  - `last_owner` resets to 3, so mem has first priority out of reset.
- OWNED ends on any of:
  - the owner's `done_i` bit is high;
  - the owner's `req_i` bit is low;
  - the watchdog limit is reached (macro only).
  - On release: `gnt_o` clears at the next edge, `last_owner` updates to the owner, and the state goes to TURN.
- TURN:
  - Arbitrate exactly as in IDLE, using the updated pointer.
  - Go to OWNED if a request is pending, otherwise IDLE.
- Requests from non-owners during OWNED are ignored. They stay pending and are not latched.
- `done_i` bits of non-owners are ignored in every state.
- `done_i` outside OWNED has no effect.
- Simultaneous owner `done_i` and watchdog expiry count as a normal release; `timeout_err_o` stays 0.
- Reset mid-grant clears `gnt_o` immediately (asynchronously) and returns to IDLE.
- Reset values:
  - `gnt_o` = 0, `owner_id_o` = 0, `bus_busy_o` = 0, `grant_event_o` = 0, `timeout_err_o` = 0;
  - state = IDLE, `last_owner` = 3, hold counter = 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Grant latency: request sampled at edge N with the bus free (IDLE or TURN) → `gnt_o` and `grant_event_o` high after edge N+1.
- Release: owner `done_i` sampled at edge M → `gnt_o` low after edge M+1 (TURN).
  - The next grant is visible after edge M+2 at the earliest.
- Back-to-back ownership by the same source still incurs one TURN cycle.
- Minimum grant length is 1 cycle.
- `owner_id_o` updates in the same cycle as `gnt_o` rises. It holds its value through TURN and IDLE.

## Configuration
- `ARB_WATCHDOG_EN` defined:
  - A hold counter of `$clog2(MAX_HOLD+1)` bits clears on every grant and increments each OWNED cycle.
  - When the count equals `MAX_HOLD` with no release, the grant drops at the next edge. `timeout_err_o` pulses in that same cycle, which is TURN.
  - Net effect: the grant lasts `MAX_HOLD`+1 cycles.
- Not defined:
  - No counter; a grant is held indefinitely until release.
  - `timeout_err_o` is driven constant 0.

## Structure
- Shared package `interconnect_pkg`:
  - `src_id_t` (2-bit);
  - source ID constants `SRC_MEM`=0, `SRC_SHA`=1, `SRC_AES`=2, `SRC_CTRL`=3;
  - the `arb_state_t` enum (IDLE, OWNED, TURN).
- One combinational sub-module, `rr_pick4`: inputs request vector and start pointer; outputs valid and winner ID.
- FSM, pointer and watchdog live in the top module.

## Test plan
- Reset then `req_i`=4'b1111 held; each owner asserts `done_i` one cycle after its grant → grant order mem, sha, aes, ctrl, mem. Each `grant_event_o` is a single pulse, 3 cycles apart.
- `req_i`=4'b0100 at edge 10, done at edge 14 → `gnt_o`=4'b0100 from edge 11 through edge 14; low after edge 15; `owner_id_o`=2 throughout.
- Owner sha; `done_i`=4'b0001 (non-owner) → no effect. Sha drops `req_i` → release, then TURN.
- Assert `rst_n`=0 mid-grant → `gnt_o`=0 and `bus_busy_o`=0 without waiting for a clock edge. After release, `req_i`=4'b1000 → ctrl granted, `last_owner` back at 3.
- With `ARB_WATCHDOG_EN` and `MAX_HOLD`=4: aes holds its request forever → grant lasts 5 cycles, `timeout_err_o` pulses once, then a pending mem request is granted after TURN.
- Without the macro: the same stimulus holds the grant for 1000 cycles and `timeout_err_o` stays 0.
